// File: rtl/xgxs_8b10b_pkg.sv
// Shared 8b/10b code constants and lookup helpers for the XGXS lane encoders.
// Sub-block tables are held for RD- in standard notation (a / f is the MSB);
// RD+ codes are the complement wherever the matching COMP mask bit is set.
package xgxs_8b10b_pkg;

  localparam logic [9:0] K28_5_RDN  = 10'h17C;
  localparam logic [9:0] K28_5_RDP  = 10'h283;
  localparam logic [9:0] BAD_SYM    = 10'h3E0;
  localparam logic [7:0] K28_5_BYTE = 8'hBC;

  // K28.y 6b code at RD-; every other K reuses the D-table 6b code
  localparam logic [5:0] K28_6B_RDN = 6'b001111;

  // 5b/6b entries whose RD+ code is the complement (unbalanced, plus D.7)
  localparam logic [31:0] T6_COMP = 32'hE981_8197;
  // 3b/4b D entries whose RD+ code is the complement (y = 0, 3, 4, 7)
  localparam logic [7:0]  D4_COMP = 8'h99;
  // alternate D.x.7 code at RD-
  localparam logic [3:0]  A7_RDN  = 4'b0111;

  typedef struct packed {
    logic [7:0] din;
    logic       k;
    logic       bad_code;
    logic       bad_disp;
  } lane_req_t;

  // idle request: K28.5 with injection masked off
  localparam lane_req_t IDLE_REQ = '{din: K28_5_BYTE, k: 1'b1, bad_code: 1'b0, bad_disp: 1'b0};

  function automatic logic [5:0] t6_rdn(input logic [4:0] x);
    logic [5:0] c;
    case (x)
      5'd0:  c = 6'b100111;  5'd1:  c = 6'b011101;
      5'd2:  c = 6'b101101;  5'd3:  c = 6'b110001;
      5'd4:  c = 6'b110101;  5'd5:  c = 6'b101001;
      5'd6:  c = 6'b011001;  5'd7:  c = 6'b111000;
      5'd8:  c = 6'b111001;  5'd9:  c = 6'b100101;
      5'd10: c = 6'b010101;  5'd11: c = 6'b110100;
      5'd12: c = 6'b001101;  5'd13: c = 6'b101100;
      5'd14: c = 6'b011100;  5'd15: c = 6'b010111;
      5'd16: c = 6'b011011;  5'd17: c = 6'b100011;
      5'd18: c = 6'b010011;  5'd19: c = 6'b110010;
      5'd20: c = 6'b001011;  5'd21: c = 6'b101010;
      5'd22: c = 6'b011010;  5'd23: c = 6'b111010;
      5'd24: c = 6'b110011;  5'd25: c = 6'b100110;
      5'd26: c = 6'b010110;  5'd27: c = 6'b110110;
      5'd28: c = 6'b001110;  5'd29: c = 6'b101110;
      5'd30: c = 6'b011110;  default: c = 6'b101011;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] d4_rdn(input logic [2:0] y);
    logic [3:0] c;
    case (y)
      3'd0: c = 4'b1011;  3'd1: c = 4'b1001;
      3'd2: c = 4'b0101;  3'd3: c = 4'b1100;
      3'd4: c = 4'b1101;  3'd5: c = 4'b1010;
      3'd6: c = 4'b0110;  default: c = 4'b1110;
    endcase
    return c;
  endfunction

  // K 3b/4b codes at RD-; all K codes complement at RD+
  function automatic logic [3:0] k4_rdn(input logic [2:0] y);
    logic [3:0] c;
    case (y)
      3'd0: c = 4'b1011;  3'd1: c = 4'b0110;
      3'd2: c = 4'b1010;  3'd3: c = 4'b1100;
      3'd4: c = 4'b1101;  3'd5: c = 4'b0101;
      3'd6: c = 4'b1001;  default: c = 4'b0111;
    endcase
    return c;
  endfunction

  function automatic logic is_legal_k(input logic [7:0] b);
    logic ok;
    case (b)
      8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
      8'hF7, 8'hFB, 8'hFD, 8'hFE: ok = 1'b1;
      default:                    ok = 1'b0;
    endcase
    return ok;
  endfunction

  // standard notation (a first) -> transmit order (a at bit 0)
  function automatic logic [5:0] rev6(input logic [5:0] v);
    logic [5:0] r;
    for (int b = 0; b < 6; b++) r[b] = v[5-b];
    return r;
  endfunction

  function automatic logic [3:0] rev4(input logic [3:0] v);
    logic [3:0] r;
    for (int b = 0; b < 4; b++) r[b] = v[3-b];
    return r;
  endfunction

endpackage

// File: rtl/xgxs_8b10b_lane_enc.sv
// Combinational single-lane 8b/10b encoder with error injection.
module xgxs_8b10b_lane_enc
  import xgxs_8b10b_pkg::*;
(
  input  logic [7:0] din,
  input  logic       k,
  input  logic       rd_in,
  input  logic       bad_code,
  input  logic       bad_disp,
  output logic [9:0] sym,
  output logic       rd_out,
  output logic       k_illegal
);

  logic [7:0] eff;
  logic [4:0] x;
  logic [2:0] y;
  logic       rd_s, rd6, a7;
  logic [5:0] c6;
  logic [3:0] c4;

  // 6b sub-block from start RD, 4b sub-block from RD after the 6b block
  always_comb begin
    k_illegal = k && !is_legal_k(din);
    // illegal K requests become K28.5 and then follow the normal path
    eff  = k_illegal ? K28_5_BYTE : din;
    x    = eff[4:0];
    y    = eff[7:5];
    rd_s = rd_in ^ bad_disp;

    c6 = (k && x == 5'd28) ? K28_6B_RDN : t6_rdn(x);
    if (rd_s && (k || T6_COMP[x])) c6 = ~c6;
    rd6 = ($countones(c6) != 3) ? ~rd_s : rd_s;

    // A7 avoids a run of five across the e i / f g h boundary
    a7 = !k && (y == 3'd7) &&
         ((!rd6 && c6[1] && c6[0]) || (rd6 && !c6[1] && !c6[0]));
    if (k)       c4 = k4_rdn(y);
    else if (a7) c4 = A7_RDN;
    else         c4 = d4_rdn(y);
    if (rd6 && (k || a7 || D4_COMP[y])) c4 = ~c4;

    sym    = {rev4(c4), rev6(c6)};
    rd_out = ($countones(c4) != 2) ? ~rd6 : rd6;

    // forced invalid symbol is balanced, so RD passes straight through
    if (bad_code) begin
      sym    = BAD_SYM;
      rd_out = rd_in;
    end
  end

endmodule

// File: rtl/xgxs_enc_8b10b_lanes.sv
// Multi-lane XGXS 8b/10b encoder: per-lane or chained RD, idle insertion,
// error injection and a saturating illegal-K counter. One register stage.
module xgxs_enc_8b10b_lanes
  import xgxs_8b10b_pkg::*;
#(
  parameter int LANES    = 4,
  parameter bit CHAIN_RD = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [8*LANES-1:0]    encode_data_in,
  input  logic [LANES-1:0]      konstant,
  input  logic [LANES-1:0]      bad_code,
  input  logic [LANES-1:0]      bad_disp,
  output logic [10*LANES-1:0]   encode_data_out,
  output logic [LANES-1:0]      disp_out,
  output logic [LANES-1:0]      k_err,
  output logic [CNT_W-1:0]      k_err_count
);

  localparam int SW = CNT_W + 4;
  localparam logic [SW-1:0] CNT_MAX = {4'b0, {CNT_W{1'b1}}};

  lane_req_t [LANES-1:0]       req;
  logic [LANES-1:0][9:0]       sym_nxt;
  logic [LANES-1:0]            rd_nxt;
  logic [LANES-1:0]            k_ill;
  logic [LANES-1:0]            kerr_nxt;
  logic [SW-1:0]               cnt_sum;
  logic [CNT_W-1:0]            cnt_nxt;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic rd_i, rd_o;

    assign req[i] = in_valid ? {encode_data_in[8*i +: 8], konstant[i], bad_code[i], bad_disp[i]}
                             : IDLE_REQ;

    // disp_out doubles as the RD register; chained mode threads RD across lanes
    if (i == 0) begin : g_src
      assign rd_i = CHAIN_RD ? disp_out[LANES-1] : disp_out[0];
    end else begin : g_src
      assign rd_i = CHAIN_RD ? g_lane[i-1].rd_o : disp_out[i];
    end

    xgxs_8b10b_lane_enc u_enc (
      .din       (req[i].din),
      .k         (req[i].k),
      .rd_in     (rd_i),
      .bad_code  (req[i].bad_code),
      .bad_disp  (req[i].bad_disp),
      .sym       (sym_nxt[i]),
      .rd_out    (rd_o),
      .k_illegal (k_ill[i])
    );

    assign rd_nxt[i] = rd_o;
  end

  assign kerr_nxt = in_valid ? k_ill : '0;

  // saturating add of this cycle's illegal-K lane count
  always_comb begin
    cnt_sum = {4'b0, k_err_count};
    for (int l = 0; l < LANES; l++) cnt_sum = cnt_sum + SW'(kerr_nxt[l]);
    cnt_nxt = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
  end

  // output register stage and RD state
  always_ff @(posedge clk) begin
    if (rst) begin
      encode_data_out <= {LANES{K28_5_RDN}};
      disp_out        <= '0;
      k_err           <= '0;
      k_err_count     <= '0;
    end else begin
      encode_data_out <= sym_nxt;
      disp_out        <= rd_nxt;
      k_err           <= kerr_nxt;
      k_err_count     <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_xgxs_enc_8b10b_lanes.sv
// Bench: two encoder instances (per-lane RD / 16-bit counter and chained RD /
// 2-bit counter) share stimulus and are compared each cycle to a table model.
module tb_xgxs_enc_8b10b_lanes;

  logic        clk = 1'b0;
  logic        rst, in_valid;
  logic [31:0] din;
  logic [3:0]  kon, bc, bd;
  logic [39:0] dout0, dout1;
  logic [3:0]  disp0, disp1, kerr0, kerr1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  xgxs_enc_8b10b_lanes #(.LANES(4), .CHAIN_RD(1'b0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .encode_data_in(din), .konstant(kon),
    .bad_code(bc), .bad_disp(bd), .encode_data_out(dout0), .disp_out(disp0),
    .k_err(kerr0), .k_err_count(cnt0));

  xgxs_enc_8b10b_lanes #(.LANES(4), .CHAIN_RD(1'b1), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .encode_data_in(din), .konstant(kon),
    .bad_code(bc), .bad_disp(bd), .encode_data_out(dout1), .disp_out(disp1),
    .k_err(kerr1), .k_err_count(cnt1));

  // code tables, both disparities written out, standard notation (a / f first)
  logic [5:0] t6n [0:31] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  logic [5:0] t6p [0:31] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  logic [3:0] d4n [0:7] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  logic [3:0] d4p [0:7] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  logic [3:0] k4n [0:7] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  logic [3:0] k4p [0:7] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
  logic [7:0] legal_k [0:11] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                                 8'hF7, 8'hFB, 8'hFD, 8'hFE};

  // model state
  logic [3:0]      m_rd0;
  logic            m_rd1;
  int              m_cnt0, m_cnt1;
  logic [3:0][9:0] e_out0, e_out1;
  logic [3:0]      e_disp0, e_disp1, e_kerr0, e_kerr1;

  // reference encoder: symbol from the tables, RD from the whole symbol's ones count
  task automatic ref_enc(input logic [7:0] b, input logic k, input logic rd,
                         input logic bcode, input logic bdisp,
                         output logic [9:0] sym, output logic rdo, output logic ill);
    logic [7:0] b2;
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       r, r6;
    int         ones;
    ill = k;
    for (int j = 0; j < 12; j++) if (k && b == legal_k[j]) ill = 1'b0;
    b2 = ill ? 8'hBC : b;
    x  = b2[4:0];
    y  = b2[7:5];
    r  = rd ^ bdisp;
    if (k && x == 5'd28) c6 = r ? 6'b110000 : 6'b001111;
    else                 c6 = r ? t6p[x] : t6n[x];
    ones = $countones(c6);
    r6 = (ones > 3) ? 1'b1 : (ones < 3) ? 1'b0 : r;
    if (k) c4 = r6 ? k4p[y] : k4n[y];
    else if (y == 3'd7 && ((!r6 && (x == 17 || x == 18 || x == 20)) ||
                           ( r6 && (x == 11 || x == 13 || x == 14))))
      c4 = r6 ? 4'b1000 : 4'b0111;
    else c4 = r6 ? d4p[y] : d4n[y];
    for (int j = 0; j < 6; j++) sym[j]   = c6[5-j];
    for (int j = 0; j < 4; j++) sym[6+j] = c4[3-j];
    ones = $countones(sym);
    rdo = (ones > 5) ? 1'b1 : (ones < 5) ? 1'b0 : r;
    if (bcode) begin
      sym = 10'h3E0;
      rdo = rd;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock, step the model with the inputs sampled at that edge, compare
  task automatic tick();
    logic [7:0] b;
    logic       k, c, d, ro, il, r;
    logic [9:0] s;
    @(posedge clk);
    #1;
    if (rst) begin
      e_out0 = {4{10'h17C}};
      e_out1 = {4{10'h17C}};
      e_disp0 = '0; e_disp1 = '0; e_kerr0 = '0; e_kerr1 = '0;
      m_rd0 = '0; m_rd1 = 1'b0; m_cnt0 = 0; m_cnt1 = 0;
    end else begin
      r = m_rd1;
      for (int l = 0; l < 4; l++) begin
        b = in_valid ? din[8*l +: 8] : 8'hBC;
        k = in_valid ? kon[l] : 1'b1;
        c = in_valid ? bc[l] : 1'b0;
        d = in_valid ? bd[l] : 1'b0;
        ref_enc(b, k, m_rd0[l], c, d, s, ro, il);
        e_out0[l] = s; m_rd0[l] = ro; e_disp0[l] = ro; e_kerr0[l] = il;
        if (il) m_cnt0 = (m_cnt0 < 65535) ? m_cnt0 + 1 : 65535;
        ref_enc(b, k, r, c, d, s, ro, il);
        e_out1[l] = s; r = ro; e_disp1[l] = ro; e_kerr1[l] = il;
        if (il) m_cnt1 = (m_cnt1 < 3) ? m_cnt1 + 1 : 3;
      end
      m_rd1 = r;
    end
    chk("u0_sym",  64'(dout0), 64'(e_out0));
    chk("u0_disp", 64'(disp0), 64'(e_disp0));
    chk("u0_kerr", 64'(kerr0), 64'(e_kerr0));
    chk("u0_cnt",  64'(cnt0),  64'(m_cnt0));
    chk("u1_sym",  64'(dout1), 64'(e_out1));
    chk("u1_disp", 64'(disp1), 64'(e_disp1));
    chk("u1_kerr", 64'(kerr1), 64'(e_kerr1));
    chk("u1_cnt",  64'(cnt1),  64'(m_cnt1));
  endtask

  logic [8:0] codes [0:267];

  initial begin
    rst = 1'b1; in_valid = 1'b0; din = '0; kon = '0; bc = '0; bd = '0;
    for (int i = 0; i < 256; i++) codes[i] = {1'b0, 8'(i)};
    for (int i = 0; i < 12; i++)  codes[256+i] = {1'b1, legal_k[i]};

    // reset state
    tick(); tick();
    chk("rst_sym", 64'(dout0), 64'({4{10'h17C}}));

    // idle alternates K28.5 polarity
    rst = 1'b0;
    tick(); chk("idle0", 64'(dout0), 64'({4{10'h17C}})); chk("idle0_disp", 64'(disp0), 64'hF);
    tick(); chk("idle1", 64'(dout0), 64'({4{10'h283}}));
    tick(); chk("idle2", 64'(dout0), 64'({4{10'h17C}}));

    // neutral D21.5 on every lane
    in_valid = 1'b1; din = {4{8'hB5}};
    repeat (3) begin tick(); chk("d21_5", 64'(dout0), 64'({4{10'h155}})); end

    // chained K28.5 from reset
    rst = 1'b1; tick(); rst = 1'b0;
    din = {4{8'hBC}}; kon = 4'hF;
    tick(); chk("chain_k", 64'(dout1), 64'({10'h283, 10'h17C, 10'h283, 10'h17C}));
    tick(); chk("chain_l0", 64'(dout1[9:0]), 64'(10'h17C));

    // illegal K (byte 0x00) on lane 2 for five cycles
    rst = 1'b1; tick(); rst = 1'b0;
    din = {8'h4A, 8'h00, 8'h4A, 8'h4A}; kon = 4'b0100;
    repeat (5) tick();
    chk("kerr_lane", 64'(kerr0), 64'h4);
    chk("kerr_cnt16", 64'(cnt0), 64'd5);
    chk("kerr_cnt2_sat", 64'(cnt1), 64'd3);

    // injection on lane 1
    kon = '0; din = 32'h1F5A_3C96;
    bc = 4'b0010; tick(); chk("bad_code", 64'(dout0[19:10]), 64'(10'h3E0));
    bc = '0; bd = 4'b0010; tick();
    bd = '0; tick();
    bc = 4'b0100; kon = 4'b0100; din = 32'h0000_0000; tick();
    bc = '0; kon = '0;

    // sweep all D bytes and legal K codes across lanes, twice for RD spread
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 268; i++) begin
        for (int l = 0; l < 4; l++) begin
          din[8*l +: 8] = codes[(i + l*67 + p*13) % 268][7:0];
          kon[l]        = codes[(i + l*67 + p*13) % 268][8];
        end
        tick();
      end

    // random traffic with occasional idle, illegal K and injections
    for (int n = 0; n < 800; n++) begin
      in_valid = ($urandom % 8) != 0;
      for (int l = 0; l < 4; l++) begin
        if ($urandom % 8 == 0) begin
          kon[l] = 1'b1;
          din[8*l +: 8] = ($urandom % 3 == 0) ? 8'($urandom) : legal_k[$urandom % 12];
        end else begin
          kon[l] = 1'b0;
          din[8*l +: 8] = 8'($urandom);
        end
        bc[l] = ($urandom % 16) == 0;
        bd[l] = ($urandom % 16) == 0;
      end
      tick();
    end

    // reset in mid-stream
    rst = 1'b1; tick();
    chk("rst_mid0", 64'(dout0), 64'({4{10'h17C}}));
    chk("rst_mid1", 64'(dout1), 64'({4{10'h17C}}));
    rst = 1'b0; in_valid = 1'b0; bc = '0; bd = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
